// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//
// Buffered instruction dispatcher between the decoder and the rename/issue
// back end. Decoded instructions are pushed into a DEPTH-entry FIFO; at most
// one instruction per cycle leaves from the head when the back end reports
// room. At dispatch the two source operands are resolved against the regfile,
// the ROB, NCDB CDB channels and a one-deep rename bypass. The block owns ROB
// tag allocation (tag 0 is reserved for "no dependency") and supports a
// misprediction flush that empties the queue and reloads the tag counter.
//
// Ports
//   clk_in, rst_n_in        clock (rising edge), asynchronous active-low reset
//   rdy_in                  global enable, low freezes state
//   flush_in, flush_tag_in  misprediction flush and next free ROB tag
//   dec_*                   decoder push handshake and instruction fields
//   regfile_rs/rt_out       head source indices (combinational)
//   regfile_*_in            regfile busy/value/reorder for the head sources
//   rob_rs/rt_h_out         ROB probe tags (combinational)
//   rob_*_in                ROB probe results
//   rob_full_in, rs_full_in back end has fewer than 2 free entries
//   cdb_*_in                packed CDB broadcast channels
//   rob_en_out, rs_en_out   registered one-cycle dispatch pulses
//   regfile_rd_*            registered rename write
//   dest_tag_out .. taken_out  registered dispatch payload
// -----------------------------------------------------------------------------
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int NCDB   = 2,
  parameter int REG_W  = 5,
  parameter int ID_W   = 32,
  parameter int ROB_W  = 4,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 6
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [ROB_W-1:0]       flush_tag_in,
  // decoder
  input  logic                   dec_valid_in,
  output logic                   dec_ready_out,
  input  logic [REG_W-1:0]       dec_rs_in,
  input  logic [REG_W-1:0]       dec_rt_in,
  input  logic [REG_W-1:0]       dec_rd_in,
  input  logic [ID_W-1:0]        dec_imm_in,
  input  logic [OP_W-1:0]        dec_opcode_in,
  input  logic [ADDR_W-1:0]      dec_pc_in,
  input  logic                   dec_taken_in,
  input  logic                   dec_wb_in,
  // regfile read
  output logic [REG_W-1:0]       regfile_rs_out,
  output logic [REG_W-1:0]       regfile_rt_out,
  input  logic                   regfile_rs_busy_in,
  input  logic                   regfile_rt_busy_in,
  input  logic [ID_W-1:0]        regfile_rs_value_in,
  input  logic [ID_W-1:0]        regfile_rt_value_in,
  input  logic [ROB_W-1:0]       regfile_rs_reorder_in,
  input  logic [ROB_W-1:0]       regfile_rt_reorder_in,
  // ROB probe
  output logic [ROB_W-1:0]       rob_rs_h_out,
  output logic [ROB_W-1:0]       rob_rt_h_out,
  input  logic                   rob_rs_ready_in,
  input  logic                   rob_rt_ready_in,
  input  logic [ID_W-1:0]        rob_rs_value_in,
  input  logic [ID_W-1:0]        rob_rt_value_in,
  // back-end occupancy
  input  logic                   rob_full_in,
  input  logic                   rs_full_in,
  // CDB
  input  logic [NCDB-1:0]        cdb_valid_in,
  input  logic [NCDB*ROB_W-1:0]  cdb_tag_in,
  input  logic [NCDB*ID_W-1:0]   cdb_value_in,
  // dispatch outputs
  output logic                   rob_en_out,
  output logic                   rs_en_out,
  output logic                   regfile_rd_en_out,
  output logic [REG_W-1:0]       regfile_rd_out,
  output logic [ROB_W-1:0]       regfile_reorder_out,
  output logic [ROB_W-1:0]       dest_tag_out,
  output logic [ROB_W-1:0]       qj_out,
  output logic [ROB_W-1:0]       qk_out,
  output logic [ID_W-1:0]        vj_out,
  output logic [ID_W-1:0]        vk_out,
  output logic [ID_W-1:0]        a_out,
  output logic [ADDR_W-1:0]      pc_out,
  output logic [OP_W-1:0]        opcode_out,
  output logic [REG_W-1:0]       rd_out,
  output logic                   taken_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [ID_W-1:0]   imm;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              wb;
  } entry_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------------
  entry_t            mem_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              bypass_valid_reg;
  logic [REG_W-1:0]  bypass_rd_reg;
  logic [ROB_W-1:0]  bypass_tag_reg;
  logic [ROB_W-1:0]  next_tag_reg;

  entry_t            push_entry;
  entry_t            head_entry;
  logic              head_valid;
  logic              push;
  logic              fire;
  logic              head_renames;
  logic [ROB_W-1:0]  tag_inc;
  logic [ROB_W-1:0]  flush_tag_fixed;

  // Ready looks at the registered count only, so a same-cycle pop never
  // makes room for a push; this keeps dec_ready_out off the back-end path.
  assign dec_ready_out = (count_reg < CNT_W'(DEPTH));
  assign head_valid    = (count_reg != '0);
  assign push          = dec_valid_in && dec_ready_out && rdy_in && !flush_in;
  assign fire          = head_valid && !rob_full_in && !rs_full_in && rdy_in && !flush_in;

  assign head_entry    = mem_reg[head_reg];
  assign head_renames  = head_entry.wb && (head_entry.rd != '0);

  // Tag 0 means "no dependency", so the allocator skips it on wrap and a
  // flush to tag 0 is promoted to 1.
  assign tag_inc         = (next_tag_reg == '1) ? ROB_W'(1) : next_tag_reg + ROB_W'(1);
  assign flush_tag_fixed = (flush_tag_in == '0) ? ROB_W'(1) : flush_tag_in;

  always_comb begin
    push_entry        = '0;
    push_entry.rs     = dec_rs_in;
    push_entry.rt     = dec_rt_in;
    push_entry.rd     = dec_rd_in;
    push_entry.imm    = dec_imm_in;
    push_entry.opcode = dec_opcode_in;
    push_entry.pc     = dec_pc_in;
    push_entry.taken  = dec_taken_in;
    push_entry.wb     = dec_wb_in;
  end

  // Payload storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_reg[tail_reg] <= push_entry;
    end
  end

  assign regfile_rs_out = head_entry.rs;
  assign regfile_rt_out = head_entry.rt;

  // ---------------------------------------------------------------------------
  // Operand resolution, one lane per source (0 = rs/j, 1 = rt/k)
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] src_idx     [2];
  logic             src_busy    [2];
  logic [ID_W-1:0]  src_rf_val  [2];
  logic [ROB_W-1:0] src_rf_tag  [2];
  logic             src_rob_rdy [2];
  logic [ID_W-1:0]  src_rob_val [2];
  logic [ROB_W-1:0] probe_tag   [2];
  logic [ROB_W-1:0] src_q       [2];
  logic [ID_W-1:0]  src_v       [2];

  assign src_idx[0]     = head_entry.rs;
  assign src_idx[1]     = head_entry.rt;
  assign src_busy[0]    = regfile_rs_busy_in;
  assign src_busy[1]    = regfile_rt_busy_in;
  assign src_rf_val[0]  = regfile_rs_value_in;
  assign src_rf_val[1]  = regfile_rt_value_in;
  assign src_rf_tag[0]  = regfile_rs_reorder_in;
  assign src_rf_tag[1]  = regfile_rt_reorder_in;
  assign src_rob_rdy[0] = rob_rs_ready_in;
  assign src_rob_rdy[1] = rob_rt_ready_in;
  assign src_rob_val[0] = rob_rs_value_in;
  assign src_rob_val[1] = rob_rt_value_in;

  assign rob_rs_h_out = probe_tag[0];
  assign rob_rt_h_out = probe_tag[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic             byp_hit;
      logic             cdb_hit;
      logic [ID_W-1:0]  cdb_val;
      logic [ROB_W-1:0] q_lane;
      logic [ID_W-1:0]  v_lane;

      // The regfile still shows the pre-rename state for the instruction
      // dispatched last cycle, so the bypass overrides it.
      assign byp_hit      = bypass_valid_reg && (src_idx[gi] == bypass_rd_reg);
      assign probe_tag[gi] = byp_hit ? bypass_tag_reg : src_rf_tag[gi];

      // Scan from the top channel down so the lowest matching channel wins.
      always_comb begin
        cdb_hit = 1'b0;
        cdb_val = '0;
        for (int c = NCDB - 1; c >= 0; c--) begin
          if (cdb_valid_in[c] && (cdb_tag_in[c*ROB_W +: ROB_W] == probe_tag[gi])) begin
            cdb_hit = 1'b1;
            cdb_val = cdb_value_in[c*ID_W +: ID_W];
          end
        end
      end

      // A bypass hit and a busy regfile entry take the same ROB-then-CDB path,
      // differing only in which tag is probed.
      always_comb begin
        q_lane = '0;
        v_lane = '0;
        if (src_idx[gi] == '0) begin
          q_lane = '0;
          v_lane = '0;
        end else if (byp_hit || src_busy[gi]) begin
          if (src_rob_rdy[gi]) begin
            v_lane = src_rob_val[gi];
          end else if (cdb_hit) begin
            v_lane = cdb_val;
          end else begin
            q_lane = probe_tag[gi];
          end
        end else begin
          v_lane = src_rf_val[gi];
        end
      end

      assign src_q[gi] = q_lane;
      assign src_v[gi] = v_lane;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control state and registered dispatch outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_reg            <= '0;
      tail_reg            <= '0;
      count_reg           <= '0;
      next_tag_reg        <= ROB_W'(1);
      bypass_valid_reg    <= 1'b0;
      bypass_rd_reg       <= '0;
      bypass_tag_reg      <= '0;
      rob_en_out          <= 1'b0;
      rs_en_out           <= 1'b0;
      regfile_rd_en_out   <= 1'b0;
      regfile_rd_out      <= '0;
      regfile_reorder_out <= '0;
      dest_tag_out        <= '0;
      qj_out              <= '0;
      qk_out              <= '0;
      vj_out              <= '0;
      vk_out              <= '0;
      a_out               <= '0;
      pc_out              <= '0;
      opcode_out          <= '0;
      rd_out              <= '0;
      taken_out           <= 1'b0;
    end else if (flush_in) begin
      // Flush wins over push, fire and the global enable.
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      next_tag_reg      <= flush_tag_fixed;
      bypass_valid_reg  <= 1'b0;
      rob_en_out        <= 1'b0;
      rs_en_out         <= 1'b0;
      regfile_rd_en_out <= 1'b0;
    end else if (rdy_in) begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (fire) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (push && !fire) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (fire && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end

      rob_en_out        <= fire;
      rs_en_out         <= fire;
      regfile_rd_en_out <= fire && head_renames;
      // Bypass lives for exactly the cycle after a renaming dispatch.
      bypass_valid_reg  <= fire && head_renames;

      if (fire) begin
        next_tag_reg        <= tag_inc;
        bypass_rd_reg       <= head_entry.rd;
        bypass_tag_reg      <= next_tag_reg;
        regfile_rd_out      <= head_entry.rd;
        regfile_reorder_out <= next_tag_reg;
        dest_tag_out        <= next_tag_reg;
        qj_out              <= src_q[0];
        qk_out              <= src_q[1];
        vj_out              <= src_v[0];
        vk_out              <= src_v[1];
        a_out               <= head_entry.imm;
        pc_out              <= head_entry.pc;
        opcode_out          <= head_entry.opcode;
        rd_out              <= head_entry.rd;
        taken_out           <= head_entry.taken;
      end
    end else begin
      rob_en_out        <= 1'b0;
      rs_en_out         <= 1'b0;
      regfile_rd_en_out <= 1'b0;
    end
  end

endmodule
